// File: rtl/ex_serial_pkg.sv
// Shared definitions for the EX stage: ALU op/select encodings, reset level,
// FSM state encoding and a small op-classification helper.
package ex_serial_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;
    localparam int SHAMT_W  = 5;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP = 8'b0000_0011;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;

    // Reset is asserted when rst_n equals this level (active-high despite the name).
    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        EX_IDLE  = 2'd0,
        EX_SHIFT = 2'd1,
        EX_DONE  = 2'd2
    } ex_state_e;

    function automatic logic is_shift_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_SLL_OP) || (op == EXE_SRL_OP) || (op == EXE_SRA_OP);
    endfunction

endpackage

// File: rtl/ex_serial_if.sv
// ID/EX inputs, pipeline control, forwarding bus and EX/MEM outputs of the EX stage.
interface ex_serial_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    import ex_serial_pkg::*;

    logic [ALUOP_W-1:0]    aluop_i;
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  mem_stall_i;
    logic                  flush_i;
    logic                  fwd_wreg_o;
    logic [REG_ADDR_W-1:0] fwd_wd_o;
    logic [DATA_W-1:0]     fwd_wdata_o;
    logic                  stallreq_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, mem_stall_i, flush_i,
        input  fwd_wreg_o, fwd_wd_o, fwd_wdata_o, stallreq_o, wd_o, wreg_o, wdata_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, mem_stall_i, flush_i,
        output fwd_wreg_o, fwd_wd_o, fwd_wdata_o, stallreq_o, wd_o, wreg_o, wdata_o
    );

endinterface

// File: rtl/ex_serial_shifter.sv
// One-bit-per-cycle shifter with IDLE/SHIFT/DONE sequencing. Latches the op and
// destination on start so the result can be retired while upstream moves on.
module serial_shifter
    import ex_serial_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  hold_i,
    input  logic                  start_i,
    input  logic [ALUOP_W-1:0]    op_i,
    input  logic [DATA_W-1:0]     value_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     acc_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    ex_state_e             state_q, state_d;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [ALUOP_W-1:0]    op_q, op_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;

    function automatic logic [DATA_W-1:0] shift_one(input logic [ALUOP_W-1:0] op,
                                                    input logic [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] sv;
        logic [DATA_W-1:0]        res;
        sv = v;
        case (op)
            EXE_SLL_OP: res = v << 1;
            EXE_SRL_OP: res = v >> 1;
            default:    res = sv >>> 1;
        endcase
        return res;
    endfunction

    // Next-state: flush returns to IDLE, downstream hold freezes everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        if (flush_i) begin
            state_d = EX_IDLE;
        end else if (!hold_i) begin
            case (state_q)
                EX_IDLE: begin
                    if (start_i) begin
                        acc_d   = value_i;
                        cnt_d   = shamt_i;
                        op_d    = op_i;
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        state_d = EX_SHIFT;
                    end
                end
                EX_SHIFT: begin
                    acc_d = shift_one(op_q, acc_q);
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = EX_DONE;
                    end
                end
                EX_DONE:  state_d = EX_IDLE;
                default:  state_d = EX_IDLE;
            endcase
        end
    end

    // State, counter, accumulator and latched op/destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EX_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= EXE_NOP_OP;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
        end
    end

    assign busy_o = (state_q == EX_SHIFT);
    assign done_o = (state_q == EX_DONE);
    assign acc_o  = acc_q;
    assign wd_o   = wd_q;
    assign wreg_o = wreg_q;

endmodule

// File: rtl/ex_serial.sv
// Execute stage: single-cycle logic ops, serial shifts with pipeline hold,
// combinational forwarding to decode and the EX/MEM output register.
module ex_serial
    import ex_serial_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_serial_if.slave   bus
);

    logic                  rst;
    logic [SHAMT_W-1:0]    shamt;
    logic                  shift_op;
    logic                  start;
    logic                  sh_busy;
    logic                  sh_done;
    logic [DATA_W-1:0]     sh_acc;
    logic [REG_ADDR_W-1:0] sh_wd;
    logic                  sh_wreg;

    logic [DATA_W-1:0]     res_data;
    logic [REG_ADDR_W-1:0] res_wd;
    logic                  res_wreg;
    logic                  fwd_wreg;

    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    assign rst      = (rst_n == RST_ENABLE);
    assign shamt    = bus.reg1_i[SHAMT_W-1:0];
    assign shift_op = (bus.alusel_i == EXE_RES_SHIFT) && is_shift_op(bus.aluop_i);
    assign start    = !sh_busy && !sh_done && shift_op && (shamt != '0);

    serial_shifter #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush_i),
        .hold_i  (bus.mem_stall_i),
        .start_i (start),
        .op_i    (bus.aluop_i),
        .value_i (bus.reg2_i),
        .shamt_i (shamt),
        .wd_i    (bus.wd_i),
        .wreg_i  (bus.wreg_i),
        .busy_o  (sh_busy),
        .done_o  (sh_done),
        .acc_o   (sh_acc),
        .wd_o    (sh_wd),
        .wreg_o  (sh_wreg)
    );

    // Result select: a finished shift wins; a running or starting shift is a bubble.
    always_comb begin
        res_data = '0;
        res_wd   = '0;
        res_wreg = 1'b0;
        if (sh_done) begin
            res_data = sh_acc;
            res_wd   = sh_wd;
            res_wreg = sh_wreg;
        end else if (!sh_busy && !start) begin
            res_wd   = bus.wd_i;
            res_wreg = bus.wreg_i;
            case (bus.alusel_i)
                EXE_RES_LOGIC: begin
                    case (bus.aluop_i)
                        EXE_OR_OP:  res_data = bus.reg1_i | bus.reg2_i;
                        EXE_AND_OP: res_data = bus.reg1_i & bus.reg2_i;
                        EXE_XOR_OP: res_data = bus.reg1_i ^ bus.reg2_i;
                        EXE_NOR_OP: res_data = ~(bus.reg1_i | bus.reg2_i);
                        default:    res_data = '0;
                    endcase
                end
                EXE_RES_SHIFT: begin
                    // Zero shift amount completes immediately with the unshifted value.
                    if (shift_op) begin
                        res_data = bus.reg2_i;
                    end
                end
                default: res_data = '0;
            endcase
        end
    end

    assign fwd_wreg        = res_wreg && !bus.flush_i;
    assign bus.fwd_wreg_o  = fwd_wreg;
    assign bus.fwd_wd_o    = res_wd;
    assign bus.fwd_wdata_o = res_data;
    assign bus.stallreq_o  = start || sh_busy;

    // EX/MEM next value: flush inserts a bubble, downstream stall holds.
    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (bus.flush_i) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
        end else if (!bus.mem_stall_i) begin
            wd_d    = res_wd;
            wreg_d  = fwd_wreg;
            wdata_d = res_data;
        end
    end

    // EX/MEM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.wd_o    = wd_q;
    assign bus.wreg_o  = wreg_q;
    assign bus.wdata_o = wdata_q;

endmodule
